// File: rtl/prco_trace_pkg.sv
// Shared definitions for the prco debug trace receiver: TX state encoding
// and UART frame constants (8 data bits, 1 stop bit, line idles high).
package prco_trace_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/prco_trace_fifo.sv
// Single-clock FIFO for captured trace bytes. Pushes while full and pops
// while empty are ignored; the read word is registered when a pop occurs.
module prco_trace_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [WIDTH-1:0]      pop_data_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level_reg == LEVEL_FULL);
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign pop_data = pop_data_reg;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage array: written only, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally modulo depth; level tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Registered read word, updated only on a successful pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_data_reg <= '0;
    else if (do_pop) pop_data_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/prco_debug_trace.sv
// Debug trace receiver: captures q_debug on each rising edge of the core's
// instruction strobe, buffers it and sends it out as 8N1 UART frames.
// Optional overflow flag / drop counter enabled by macro PRCO_TRACE_OVF_EN.
module prco_debug_trace
  import prco_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en,
  input  logic [7:0]               i_debug,
  input  logic                     i_debug_instr_clk,
  output logic                     q_tx,
  output logic                     q_busy,
  output logic [FIFO_DEPTH_LOG2:0] q_fifo_level,
  output logic                     q_ovf,
  output logic [7:0]               q_drop_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic              instr_clk_prev_reg;
  logic              capture_req;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rd_data;
  tx_state_t         state_reg;
  tx_state_t         state_next;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic              baud_last;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;

  // Previous strobe level for rising-edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) instr_clk_prev_reg <= 1'b0;
    else         instr_clk_prev_reg <= i_debug_instr_clk;
  end

  // A write while full is dropped; full is sampled before any same-cycle pop
  assign capture_req = i_en & i_debug_instr_clk & ~instr_clk_prev_reg;
  assign fifo_push   = capture_req & ~fifo_full;
  assign fifo_pop    = (state_reg == TX_IDLE) & ~fifo_empty;
  assign baud_last   = (baud_cnt_reg == BAUD_MAX);

  prco_trace_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (fifo_push),
    .push_data (i_debug),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (q_fifo_level)
  );

  // TX state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= TX_IDLE;
    else         state_reg <= state_next;
  end

  // TX next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TX_IDLE:  if (!fifo_empty) state_next = TX_START;
      TX_START: if (baud_last) state_next = TX_DATA;
      TX_DATA:  if (baud_last && bit_cnt_reg == LAST_BIT) state_next = TX_STOP;
      TX_STOP:  if (baud_last) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // Baud counter: runs 0..CLKS_PER_BIT-1 while a frame is in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                    baud_cnt_reg <= '0;
    else if (state_reg == TX_IDLE)  baud_cnt_reg <= '0;
    else if (baud_last)             baud_cnt_reg <= '0;
    else                            baud_cnt_reg <= baud_cnt_reg + 1'b1;
  end

  // Bit counter and shift register; popped byte is loaded as the start bit ends
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (fifo_pop) bit_cnt_reg <= '0;
      else if (state_reg == TX_DATA && baud_last) bit_cnt_reg <= bit_cnt_reg + 1'b1;
      if (state_reg == TX_START && baud_last) shift_reg <= fifo_rd_data;
      else if (state_reg == TX_DATA && baud_last) shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // Line level and busy indication derived from the current state
  always_comb begin
    q_tx   = IDLE_LEVEL;
    q_busy = (state_reg != TX_IDLE) | ~fifo_empty;
    case (state_reg)
      TX_START: q_tx = ~IDLE_LEVEL;
      TX_DATA:  q_tx = shift_reg[0];
      default:  q_tx = IDLE_LEVEL;
    endcase
  end

`ifdef PRCO_TRACE_OVF_EN
  logic       drop;
  logic       ovf_reg;
  logic [7:0] drop_cnt_reg;

  assign drop = capture_req & fifo_full;

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign q_ovf      = ovf_reg;
  assign q_drop_cnt = drop_cnt_reg;
`else
  assign q_ovf      = 1'b0;
  assign q_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_prco_debug_trace.sv
// Bench for prco_debug_trace (CLKS_PER_BIT=4, depth 16). A queue-based
// reference model predicts the line level, FIFO level, busy and drop status
// every cycle from frame timing arithmetic.
module tb_prco_debug_trace;

  localparam int CPB   = 4;
  localparam int DLOG  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] dbg;
  logic       strb;
  logic       q_tx;
  logic       q_busy;
  logic [DLOG:0] q_fifo_level;
  logic       q_ovf;
  logic [7:0] q_drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0] mq[$];
  int         fr_start = -100000;
  logic [7:0] fr_byte  = 8'h00;
  logic       prev_m   = 1'b0;
  int         drops    = 0;
  int         max_lvl  = 0;

  prco_debug_trace #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (DLOG)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_en              (en),
    .i_debug           (dbg),
    .i_debug_instr_clk (strb),
    .q_tx              (q_tx),
    .q_busy            (q_busy),
    .q_fifo_level      (q_fifo_level),
    .q_ovf             (q_ovf),
    .q_drop_cnt        (q_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (cyc >= fr_start && cyc < fr_start + FRAME) begin
      k = (cyc - fr_start) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return fr_byte[k-1];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (mq.size() > 0) || (cyc >= fr_start && cyc < fr_start + FRAME);
  endfunction

  task automatic model_reset();
    mq.delete();
    fr_start = -100000;
    prev_m   = 1'b0;
    drops    = 0;
  endtask

  task automatic model_step();
    logic rise;
    logic was_full;
    rise     = strb && !prev_m;
    prev_m   = strb;
    was_full = (mq.size() == DEPTH);
    if (cyc >= fr_start + FRAME && mq.size() > 0) begin
      fr_byte  = mq.pop_front();
      fr_start = cyc + 1;
    end
    if (rise && en) begin
      if (!was_full) mq.push_back(dbg);
      else if (drops < 255) drops++;
    end
  endtask

  // one clock cycle: compare at the falling edge, then advance the model
  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    chk("tx", 32'(q_tx), 32'(exp_tx()));
    chk("level", 32'(q_fifo_level), 32'(mq.size()));
    chk("busy", 32'(q_busy), 32'(exp_busy()));
`ifdef PRCO_TRACE_OVF_EN
    chk("ovf", 32'(q_ovf), 32'(drops > 0));
    chk("drop_cnt", 32'(q_drop_cnt), 32'(drops));
`else
    chk("ovf", 32'(q_ovf), 32'd0);
    chk("drop_cnt", 32'(q_drop_cnt), 32'd0);
`endif
    if (32'(q_fifo_level) > 32'(max_lvl)) max_lvl = int'(q_fifo_level);
    if (!rst) model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dbg = 8'h00; strb = 1'b0;
    // reset for two cycles
    run(2);
    rst = 1'b0;
    run(3);

    // single capture of 0xA5
    dbg = 8'hA5; strb = 1'b1;
    tick();
    strb = 1'b0;
    run(46);

    // held strobe: exactly one frame of 0x3C
    dbg = 8'h3C; strb = 1'b1;
    run(10);
    strb = 1'b0;
    run(45);

    // overflow: 20 strobes every 2 cycles
    max_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      dbg = 8'(i); strb = 1'b1;
      tick();
      strb = 1'b0;
      tick();
    end
    chk("ovf_peak_level", 32'(max_lvl), 32'd16);
`ifdef PRCO_TRACE_OVF_EN
    chk("ovf_flag_end", 32'(q_ovf), 32'd1);
    chk("ovf_drops_end", 32'(q_drop_cnt), 32'd3);
`else
    chk("ovf_flag_end", 32'(q_ovf), 32'd0);
    chk("ovf_drops_end", 32'(q_drop_cnt), 32'd0);
`endif
    run(17 * (FRAME + 1) + 10);
    chk("drained_level", 32'(q_fifo_level), 32'd0);

    // disabled capture
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dbg = 8'(8'h50 + i); strb = 1'b1;
      tick();
      strb = 1'b0;
      tick();
    end
    en = 1'b1;
    run(4);

    // reset during DATA with three bytes queued
    for (int i = 0; i < 4; i++) begin
      dbg = 8'(8'hC0 + i); strb = 1'b1;
      tick();
      strb = 1'b0;
      tick();
    end
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(60);

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      dbg  = 8'($urandom);
      strb = ($urandom_range(0, 3) == 0) ? ~strb : strb;
      tick();
    end
    strb = 1'b0;
    run(20);

    // final reset clears sticky status
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prco_debug_trace.md
# prco_debug_trace

Debug trace receiver for the prco core's debug port. It captures the core's 8-bit `q_debug` value on every rising edge of `q_debug_instr_clk` and buffers the captured bytes in a small FIFO. It then serialises them out of a single UART TX pin (8N1, LSB first) for host-side logging. It sits beside `prco_core` at the top level, on the same clock, and is purely an observer: it never back-pressures the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `i_clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2^N bytes (16).

Ports:
- `i_clk`  in  1: system clock, same clock as `prco_core`.
- `i_reset`  in  1: reset, asynchronous, active-high.
- `i_en`  in  1: capture enable. Low means no new captures.
- `i_debug`  in  8: connected to core `q_debug`.
- `i_debug_instr_clk`  in  1: connected to core `q_debug_instr_clk`.
- `q_tx`  out  1: UART serial output, idles high.
- `q_busy`  out  1: high while the FIFO is non-empty or a frame is in flight.
- `q_fifo_level`  out  FIFO_DEPTH_LOG2+1: current FIFO occupancy.
- `q_ovf`  out  1: sticky overflow flag.
- `q_drop_cnt`  out  8: count of dropped samples, saturating.

## Operation
- **Capture**
  - Register the previous `i_debug_instr_clk`. A rising edge is current = 1 and previous = 0.
  - On a rising edge with `i_en` = 1, write the current-cycle `i_debug` to the FIFO.
  - A strobe held high yields exactly one capture.
- **Full**
  - `full` is evaluated at the start of the cycle. A write while full is dropped, even if a pop happens in the same cycle.
  - A simultaneous write and pop while not full leaves the level unchanged.
- **TX FSM**
  - States: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START.
  - START: `q_tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits LSB first, CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: `q_tx` = 1 for CLKS_PER_BIT cycles, then return to IDLE.
- **Enable:** `i_en` deassertion does not abort a frame, and the FIFO continues to drain.
- **Reset values** (immediate, asynchronous):
  - `q_tx` = 1, FSM = IDLE, FIFO empty, `q_fifo_level` = 0.
  - `q_busy` = 0, `q_ovf` = 0, `q_drop_cnt` = 0, edge register = 0.
  - Reset mid-frame truncates the frame, and `q_tx` goes high at once.
- **Counters:** the baud counter counts 0..CLKS_PER_BIT-1 and wraps. FIFO pointers are FIFO_DEPTH_LOG2 bits and wrap modulo depth.

## Timing
- Strobe rising edge visible in cycle N: write at the end of N, and `q_fifo_level` increments in N+1.
- TX in IDLE pops in N+1, and `q_tx` falls in N+2. Capture-to-start-bit latency is 2 cycles.
- One frame lasts 10·CLKS_PER_BIT cycles.
- Back-to-back frames are separated by exactly 1 idle cycle (the IDLE pop cycle), with `q_tx` = 1.
- `q_busy` is combinational from the state and FIFO-empty signals.

## Configuration
- `PRCO_TRACE_OVF_EN` defined:
  - Each dropped write sets `q_ovf`, which stays sticky until reset.
  - Each dropped write increments `q_drop_cnt`, which saturates at 255.
- Not defined: `q_ovf` and `q_drop_cnt` are tied to 0. Drops are silent, and no counter logic is synthesised.
- Ports are present in both cases.

## Structure
- Shared package `prco_trace_pkg`:
  - TX state encodings (IDLE = 0, START = 1, DATA = 2, STOP = 3).
  - UART frame constants: 8 data bits, 1 stop bit, idle level 1.
- Sub-module `prco_trace_fifo`: synchronous, single-clock FIFO.
  - Write, read, full, empty and level signals, with async reset.
  - Read data is registered on pop.
- Top level holds the edge detector, TX FSM, baud counter and overflow logic.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and FIFO_DEPTH_LOG2 = 4.
- **Reset:** assert `i_reset` for 2 cycles → `q_tx` = 1, `q_fifo_level` = 0, `q_busy` = 0, `q_ovf` = 0.
- **Single capture:** `i_debug` = 0xA5 with a 1-cycle strobe at cycle N.
  - `q_tx` falls at N+2 and is low for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 follow, 4 cycles each, then the stop bit is high for 4 cycles.
  - `q_busy` falls at N+42.
- **Held strobe:** strobe held high for 10 cycles with `i_debug` = 0x3C → exactly one frame carrying 0x3C.
- **Overflow:** 20 strobes, one every 2 cycles, with values 0x00..0x13.
  - Level peaks at 16.
  - With the macro: `q_ovf` = 1 and `q_drop_cnt` = 3. Without it: both are 0.
  - Serial output is 0x00..0x10 in order, with 0x11..0x13 absent.
- **Disabled:** `i_en` = 0 with 5 strobes → `q_fifo_level` stays 0, `q_tx` stays 1, `q_busy` stays 0.
- **Reset mid-frame:** assert `i_reset` during DATA with 3 bytes queued.
  - `q_tx` = 1 and `q_fifo_level` = 0 in the same cycle.
  - No further frames after release.
